axi_lite_master_bridge: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 13 +
 rtl/axi_lite_rd_chan.sv | 75 +++++++
 rtl/axi_lite_master_bridge.sv | 131 +++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions for the master bridge: response codes, protection
// default and the write/read FSM state encodings.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ACK} r_state_t;
endpackage

// File: rtl/axi_lite_rd_chan.sv
// Read path of the AXI-lite master bridge: AR issue, R capture and the
// one-cycle completion pulse back to the memory-side master.
module axi_lite_rd_chan
  import axi_lite_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [AW-1:0] m_araddr,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rvalid,
  output logic          m_rready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          rerr
);
  r_state_t state, state_nx;
  logic     err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      R_IDLE: if (ren)       state_nx = R_ADDR;
      R_ADDR: if (m_arready) state_nx = R_DATA;
      R_DATA: if (m_rvalid)  state_nx = R_ACK;
      R_ACK:                 state_nx = R_IDLE;
      default:               state_nx = R_IDLE;
    endcase
  end

  // arvalid is always high in R_ADDR and rready in R_DATA, so ready/valid alone mark the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        R_IDLE: if (ren) begin
          m_araddr  <= raddr;
          m_arvalid <= 1'b1;
        end
        R_ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
        end
        R_DATA: if (m_rvalid) begin
          rdata    <= m_rdata;
          err      <= (m_rresp != RESP_OKAY);
          m_rready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rvalid = (state == R_ACK);
    rerr   = rvalid & err;
  end
endmodule

// File: rtl/axi_lite_master_bridge.sv
// Memory-style request port to AXI-lite master bridge. Independent read and
// write paths, one outstanding transaction each; write FSM lives here.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wen_mem,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   waddr_mem,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_mem,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wmask_mem,
  output logic                            wvalid_mem,
  input  logic                            ren_mem,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   raddr_mem,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_mem,
  output logic                            rvalid_mem,
  output logic                            err_mem,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]                      m_awprot,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  input  logic [1:0]                      m_bresp,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]                      m_arprot,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rvalid,
  output logic                            m_rready
);
  w_state_t w_state, w_state_nx;
  logic     aw_done, w_done, w_err;
  logic     aw_done_nx, w_done_nx;
  logic     rd_err;

  assign m_awprot = AXI_PROT_DEFAULT;
  assign m_arprot = AXI_PROT_DEFAULT;

  // AW and W complete independently; the flags fold in this cycle's handshakes
  assign aw_done_nx = aw_done | (m_awvalid & m_awready);
  assign w_done_nx  = w_done  | (m_wvalid  & m_wready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE: if (wen_mem)                w_state_nx = W_REQ;
      W_REQ:  if (aw_done_nx & w_done_nx) w_state_nx = W_RESP;
      W_RESP: if (m_bvalid)               w_state_nx = W_ACK;
      W_ACK:                              w_state_nx = W_IDLE;
      default:                            w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (wen_mem) begin
          m_awaddr  <= waddr_mem;
          m_wdata   <= wdata_mem;
          m_wstrb   <= wmask_mem;
          m_awvalid <= 1'b1;
          m_wvalid  <= 1'b1;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
        end
        W_REQ: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          aw_done <= aw_done_nx;
          w_done  <= w_done_nx;
          if (aw_done_nx & w_done_nx) m_bready <= 1'b1;
        end
        W_RESP: if (m_bvalid) begin
          m_bready <= 1'b0;
          w_err    <= (m_bresp != RESP_OKAY);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wvalid_mem = (w_state == W_ACK);
    err_mem    = (wvalid_mem & w_err) | rd_err;
  end

  axi_lite_rd_chan #(
    .DW(C_M_AXI_DATA_WIDTH),
    .AW(C_M_AXI_ADDR_WIDTH)
  ) u_rd (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren_mem),
    .raddr    (raddr_mem),
    .m_araddr (m_araddr),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .rdata    (rdata_mem),
    .rvalid   (rvalid_mem),
    .rerr     (rd_err)
  );
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge: hand-computed expectations for
// write/read timing, stalls, error responses, concurrency and async reset.
module tb_axi_lite_master_bridge;
  localparam int DW = 64;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen_mem = 1'b0, ren_mem = 1'b0;
  logic [AW-1:0] waddr_mem = '0, raddr_mem = '0;
  logic [DW-1:0] wdata_mem = '0;
  logic [7:0]    wmask_mem = '0;
  logic          wvalid_mem, rvalid_mem, err_mem;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_wstrb;
  logic          m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
  logic [DW-1:0] m_rdata = '0;
  logic          m_bvalid, m_rvalid;
  // slave responses: explicit drive, or auto-response in the same cycle as ready
  logic          bvalid_drv = 1'b0, b_auto = 1'b0;
  logic          rvalid_drv = 1'b0, r_auto = 1'b0;

  assign m_bvalid = bvalid_drv | (b_auto & m_bready);
  assign m_rvalid = rvalid_drv | (r_auto & m_rready);

  int n_pass = 0, n_total = 0;
  int wcnt, rcnt;
  logic          last_err;
  logic [DW-1:0] last_rdata;

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wen_mem(wen_mem), .waddr_mem(waddr_mem), .wdata_mem(wdata_mem), .wmask_mem(wmask_mem),
    .wvalid_mem(wvalid_mem),
    .ren_mem(ren_mem), .raddr_mem(raddr_mem), .rdata_mem(rdata_mem), .rvalid_mem(rvalid_mem),
    .err_mem(err_mem),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // run up to budget cycles counting completion pulses; the master drops its
  // request in the pulse cycle, as the mem-side contract requires
  task automatic run(input int budget);
    wcnt = 0; rcnt = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (wvalid_mem) begin wcnt++; last_err = err_mem; wen_mem = 1'b0; end
      if (rvalid_mem) begin rcnt++; last_err = err_mem; last_rdata = rdata_mem; ren_mem = 1'b0; end
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                     wvalid_mem, rvalid_mem, err_mem}, 64'h0);
    chk("rst_rdata", rdata_mem, 64'h0);
    chk("rst_awaddr", m_awaddr, 64'h0);
    rst = 1'b0;
    tick();

    // T1: fully ready slave, minimum latency
    wen_mem = 1'b1; waddr_mem = 64'h1000_0000; wdata_mem = 64'hDEADBEEF_00000041;
    wmask_mem = 8'h01; m_awready = 1'b1; m_wready = 1'b1;
    tick();
    chk("t1_c1_valids", {m_awvalid, m_wvalid, m_bready}, 64'b110);
    chk("t1_awaddr", m_awaddr, 64'h1000_0000);
    chk("t1_wdata", m_wdata, 64'hDEADBEEF_00000041);
    chk("t1_wstrb", m_wstrb, 64'h01);
    chk("t1_awprot", m_awprot, 64'h0);
    tick();
    chk("t1_c2_valids", {m_awvalid, m_wvalid, m_bready}, 64'b001);
    chk("t1_c2_nopulse", wvalid_mem, 64'h0);
    bvalid_drv = 1'b1; m_bresp = 2'b00;
    tick();
    chk("t1_c3_pulse", {wvalid_mem, err_mem, m_bready}, 64'b100);
    bvalid_drv = 1'b0; wen_mem = 1'b0;
    tick();
    chk("t1_c4_done", wvalid_mem, 64'h0);

    // T2: wready four cycles after awready
    wen_mem = 1'b1; waddr_mem = 64'h1000_0008; wdata_mem = 64'h0123_4567_89AB_CDEF;
    wmask_mem = 8'hFF; m_awready = 1'b1; m_wready = 1'b0; b_auto = 1'b1;
    tick();
    chk("t2_c1_valids", {m_awvalid, m_wvalid}, 64'b11);
    tick();
    chk("t2_c2_valids", {m_awvalid, m_wvalid}, 64'b01);
    tick();
    tick();
    chk("t2_c4_wvalid", {m_awvalid, m_wvalid, m_bready}, 64'b010);
    chk("t2_c4_wdata", m_wdata, 64'h0123_4567_89AB_CDEF);
    tick();
    m_wready = 1'b1;
    run(8);
    chk("t2_pulses", wcnt, 64'd1);
    chk("t2_err", last_err, 64'h0);
    chk("t2_wvalid_low", m_wvalid, 64'h0);
    b_auto = 1'b0;

    // T3: read with arready delayed 2 cycles, rvalid 3 cycles after rready
    ren_mem = 1'b1; raddr_mem = 64'h1000_0005; m_arready = 1'b0;
    tick();
    chk("t3_c1_arvalid", m_arvalid, 64'h1);
    chk("t3_araddr", m_araddr, 64'h1000_0005);
    chk("t3_arprot", m_arprot, 64'h0);
    tick();
    chk("t3_c2_arvalid", {m_arvalid, m_rready}, 64'b10);
    m_arready = 1'b1;
    tick();
    chk("t3_c3_rready", {m_arvalid, m_rready}, 64'b01);
    m_arready = 1'b0;
    tick();
    tick();
    chk("t3_c5_wait", {m_rready, rvalid_mem}, 64'b10);
    m_rdata = 64'h55; m_rresp = 2'b00; rvalid_drv = 1'b1;
    tick();
    chk("t3_c6_pulse", {rvalid_mem, err_mem, m_rready}, 64'b100);
    chk("t3_rdata", rdata_mem, 64'h55);
    rvalid_drv = 1'b0; ren_mem = 1'b0; m_rdata = '0;
    run(4);
    chk("t3_no_extra", rcnt, 64'd0);
    chk("t3_rdata_hold", rdata_mem, 64'h55);

    // T4: SLVERR read, data passed through
    ren_mem = 1'b1; raddr_mem = 64'h1000_0010; m_arready = 1'b1;
    m_rdata = 64'hCAFE_F00D_0000_1234; m_rresp = 2'b10; r_auto = 1'b1;
    tick();
    tick();
    chk("t4_c2_rready", m_rready, 64'h1);
    tick();
    chk("t4_c3_pulse", {rvalid_mem, err_mem}, 64'b11);
    chk("t4_rdata", rdata_mem, 64'hCAFE_F00D_0000_1234);
    ren_mem = 1'b0;
    tick();
    chk("t4_c4_done", {rvalid_mem, err_mem}, 64'b00);
    r_auto = 1'b0; m_rresp = 2'b00;

    // T5: simultaneous write and read
    wen_mem = 1'b1; waddr_mem = 64'h2000_0000; wdata_mem = 64'h11; wmask_mem = 8'h0F;
    ren_mem = 1'b1; raddr_mem = 64'h3000_0000; m_rdata = 64'h77;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; b_auto = 1'b1; r_auto = 1'b1;
    tick();
    chk("t5_c1_both", {m_awvalid, m_wvalid, m_arvalid}, 64'b111);
    tick();
    chk("t5_c2_readies", {m_bready, m_rready}, 64'b11);
    tick();
    chk("t5_c3_pulses", {wvalid_mem, rvalid_mem, err_mem}, 64'b110);
    chk("t5_rdata", rdata_mem, 64'h77);
    wen_mem = 1'b0; ren_mem = 1'b0;
    tick();
    b_auto = 1'b0; r_auto = 1'b0;

    // T6: async reset while waiting in W_RESP, then a clean write
    wen_mem = 1'b1; waddr_mem = 64'h4000_0000; wdata_mem = 64'h99; wmask_mem = 8'h03;
    tick();
    tick();
    chk("t6_in_resp", m_bready, 64'h1);
    wen_mem = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                        wvalid_mem, rvalid_mem, err_mem}, 64'h0);
    chk("t6_rst_regs", {m_awaddr, m_wstrb}, 64'h0);
    chk("t6_rst_rdata", rdata_mem, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run(3);
    chk("t6_no_stale", wcnt, 64'd0);
    wen_mem = 1'b1; waddr_mem = 64'h4000_0008; wdata_mem = 64'hAA; b_auto = 1'b1;
    m_bresp = 2'b11;
    run(6);
    chk("t6_new_pulse", wcnt, 64'd1);
    chk("t6_decerr", last_err, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
